// File: rtl/mem_responder_pkg.sv
// Shared definitions for the TinyRV1 data-memory responder: request type
// encodings and the responder FSM state type.
package mem_responder_pkg;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_array.sv
// Word storage for mem_responder: one synchronous write port and a
// combinational read of the same word. Contents are never reset.
module mem_responder_array #(
  parameter int p_num_words = 256,
  parameter int p_idx_w     = $clog2(p_num_words)
) (
  input  logic               i_clk,
  input  logic               i_we,
  input  logic [p_idx_w-1:0] i_addr,
  input  logic [31:0]        i_wdata,
  output logic [31:0]        o_rdata
);

  logic [31:0] M [p_num_words];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      M[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = M[i_addr];

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding load/store responder with a fixed, configurable
// latency between request acceptance and response valid.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int p_num_words = 256,
  parameter int p_latency   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_val,
  input  logic        resp_rdy,
  output logic        resp_type,
  output logic [31:0] resp_data
);

  localparam int IW = $clog2(p_num_words);
  localparam int CW = (p_latency > 1) ? $clog2(p_latency) : 1;

  if (p_latency < 1) begin : g_bad_latency
    $error("mem_responder: p_latency must be at least 1");
  end
  if ((p_num_words < 2) || ((p_num_words & (p_num_words - 1)) != 0)) begin : g_bad_words
    $error("mem_responder: p_num_words must be a power of two and at least 2");
  end

  state_t          r_state;
  logic [CW-1:0]   r_count;
  logic            r_type;
  logic [IW-1:0]   r_index;
  logic [31:0]     r_wdata;
  logic            r_resp_type;
  logic [31:0]     r_resp_data;

  logic            w_access;
  logic            w_we;
  logic [31:0]     w_rdata;
  logic            w_unused_addr;

  // Byte-offset and above-storage address bits are deliberately discarded.
  assign w_unused_addr = ^{req_addr[31:IW+2], req_addr[1:0]};

  assign w_access = (r_state == WAIT) && (r_count == '0);
  assign w_we     = w_access && (r_type == MEM_WRITE);

  mem_responder_array #(
    .p_num_words (p_num_words),
    .p_idx_w     (IW)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_addr  (r_index),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_type      <= MEM_READ;
      r_index     <= '0;
      r_wdata     <= '0;
      r_resp_type <= MEM_READ;
      r_resp_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_val) begin
            r_type  <= req_type;
            r_index <= req_addr[2 +: IW];
            r_wdata <= req_wdata;
            r_count <= CW'(p_latency - 1);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          // The memory access itself happens on the edge that leaves WAIT.
          if (w_access) begin
            r_resp_type <= r_type;
            r_resp_data <= (r_type == MEM_READ) ? w_rdata : 32'h0;
            r_state     <= RESP;
          end else begin
            r_count <= r_count - CW'(1);
          end
        end
        RESP: begin
          if (resp_rdy) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_rdy   = (r_state == IDLE);
  assign resp_val  = (r_state == RESP);
  assign resp_type = r_resp_type;
  assign resp_data = r_resp_data;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus randomized
// transactions compared against an array-based memory model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int NUM_WORDS = 256;
  localparam int LATENCY   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_val;
  logic        req_rdy;
  logic        req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_val;
  logic        resp_rdy;
  logic        resp_type;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NUM_WORDS];

  mem_responder #(
    .p_num_words (NUM_WORDS),
    .p_latency   (LATENCY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_val  (resp_val),
    .resp_rdy  (resp_rdy),
    .resp_type (resp_type),
    .resp_data (resp_data)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int wordIndex(input logic [31:0] addr);
    return int'((addr / 32'd4) % NUM_WORDS);
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] value);
    model[idx] = value;
    dut.u_array.M[idx] <= value;
    #0;
  endtask

  // One full transaction: accept, measure latency, optionally stall in RESP.
  task automatic applyStimulus(input logic isWrite, input logic [31:0] addr,
                               input logic [31:0] wdata, input int holdCycles,
                               input string tag);
    int n;
    logic [31:0] expData;
    checkOutput({tag, " req_rdy idle"}, 32'(req_rdy), 32'd1);
    req_val   = 1'b1;
    req_type  = isWrite;
    req_addr  = addr;
    req_wdata = wdata;
    expData   = isWrite ? 32'h0 : model[wordIndex(addr)];
    if (isWrite) model[wordIndex(addr)] = wdata;
    nextCycle();
    req_val   = 1'b0;
    req_type  = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    n = 0;
    while (!resp_val && n < 50) begin
      checkOutput({tag, " req_rdy wait"}, 32'(req_rdy), 32'd0);
      nextCycle();
      n++;
    end
    checkOutput({tag, " latency"}, 32'(n), 32'(LATENCY));
    for (int h = 0; h < holdCycles; h++) begin
      checkOutput({tag, " hold resp_val"}, 32'(resp_val), 32'd1);
      checkOutput({tag, " hold resp_data"}, resp_data, expData);
      checkOutput({tag, " hold req_rdy"}, 32'(req_rdy), 32'd0);
      req_val  = 1'($urandom);
      req_addr = $urandom;
      nextCycle();
    end
    checkOutput({tag, " resp_val"}, 32'(resp_val), 32'd1);
    checkOutput({tag, " resp_type"}, 32'(resp_type), 32'(isWrite));
    checkOutput({tag, " resp_data"}, resp_data, expData);
    resp_rdy = 1'b1;
    nextCycle();
    resp_rdy = 1'b0;
    req_val  = 1'b0;
    checkOutput({tag, " resp_val after"}, 32'(resp_val), 32'd0);
    checkOutput({tag, " req_rdy after"}, 32'(req_rdy), 32'd1);
  endtask

  // Reset hits an in-flight write either before (WAIT) or after (RESP) it commits.
  task automatic resetDuring(input logic inResp, input string tag);
    logic [31:0] expWord;
    preload(2, 32'h0000_0001);
    req_val   = 1'b1;
    req_type  = MEM_WRITE;
    req_addr  = 32'h0000_0008;
    req_wdata = 32'h5555_5555;
    nextCycle();
    req_val = 1'b0;
    if (inResp) begin
      repeat (LATENCY) nextCycle();
      checkOutput({tag, " pre resp_type"}, 32'(resp_type), 32'd1);
      model[2] = 32'h5555_5555;
    end
    expWord = model[2];
    #2 rst = 1'b1;
    #1;
    checkOutput({tag, " rst resp_val"}, 32'(resp_val), 32'd0);
    checkOutput({tag, " rst req_rdy"}, 32'(req_rdy), 32'd1);
    checkOutput({tag, " rst resp_type"}, 32'(resp_type), 32'd0);
    checkOutput({tag, " rst resp_data"}, resp_data, 32'd0);
    nextCycle();
    rst = 1'b0;
    nextCycle();
    checkOutput({tag, " M[2]"}, dut.u_array.M[2], expWord);
  endtask

  // Continuous requests with resp_rdy tied high; responses checked in order.
  task automatic backToBack(input int cycles);
    logic [32:0] expQ [$];
    logic [32:0] exp;
    int lastResp;
    int idx;
    lastResp = -1;
    resp_rdy = 1'b1;
    for (int c = 0; c < cycles + 10; c++) begin
      if (c < cycles) begin
        req_val   = 1'b1;
        req_type  = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
      end else begin
        req_val = 1'b0;
      end
      if (resp_val) begin
        if (expQ.size() == 0) begin
          checkOutput("b2b unexpected resp", 32'(resp_val), 32'd0);
        end else begin
          exp = expQ.pop_front();
          checkOutput("b2b resp_type", 32'(resp_type), 32'(exp[32]));
          checkOutput("b2b resp_data", resp_data, exp[31:0]);
        end
        if (lastResp >= 0) checkOutput("b2b period", 32'(c - lastResp), 32'(LATENCY + 2));
        lastResp = c;
      end
      if (req_rdy && req_val) begin
        idx = wordIndex(req_addr);
        if (req_type == MEM_WRITE) begin
          expQ.push_back({1'b1, 32'h0});
          model[idx] = req_wdata;
        end else begin
          expQ.push_back({1'b0, model[idx]});
        end
      end
      nextCycle();
    end
    checkOutput("b2b drained", 32'(expQ.size()), 32'd0);
    resp_rdy = 1'b0;
    req_val  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    rst       = 1'b1;
    req_val   = 1'b0;
    req_type  = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    resp_rdy  = 1'b0;
    for (int i = 0; i < NUM_WORDS; i++) preload(i, $urandom);
    #1;
    checkOutput("reset resp_val", 32'(resp_val), 32'd0);
    checkOutput("reset req_rdy", 32'(req_rdy), 32'd1);
    checkOutput("reset resp_type", 32'(resp_type), 32'd0);
    checkOutput("reset resp_data", resp_data, 32'd0);
    repeat (2) nextCycle();
    rst = 1'b0;
    nextCycle();

    preload(4, 32'h0000_cafe);
    applyStimulus(MEM_READ, 32'h10, 32'h0, 0, "read cafe");
    applyStimulus(MEM_WRITE, 32'h20, 32'hdead_beef, 0, "write 0x20");
    applyStimulus(MEM_READ, 32'h20, 32'h0, 0, "read 0x20");
    applyStimulus(MEM_READ, 32'h23, 32'h0, 0, "read 0x23");
    applyStimulus(MEM_READ, 32'h10, 32'h0, 5, "stall");
    preload(0, 32'h0000_1234);
    applyStimulus(MEM_READ, 32'h400, 32'h0, 0, "wrap");

    applyStimulus(MEM_READ, 32'h10, 32'h0, 0, "pre reset read");
    resetDuring(1'b0, "rst in WAIT");
    applyStimulus(MEM_READ, 32'h8, 32'h0, 0, "read after WAIT rst");
    resetDuring(1'b1, "rst in RESP");
    applyStimulus(MEM_READ, 32'h8, 32'h0, 0, "read after RESP rst");

    backToBack(40);

    for (int t = 0; t < 30; t++) begin
      a = $urandom;
      a[9:2] = 8'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
